// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1.sv - glitch-free programmable clock divider with run/stop
//
// Purpose:
//   Divides CLK by R = SH + 2 and drives the registered result on Z. The
//   shadow divisor SH only changes at period boundaries, so changes to the
//   ratio never produce a runt pulse. Stopping also waits for the period
//   boundary. Z always finishes its current period and then parks low.
//
// Ports:
//   CLK      - source clock; all state changes on its rising edge
//   RN       - asynchronous active-low reset
//   EN       - run request, level sensitive
//   DIV      - requested divisor, held stable while DIV_REQ is high
//   DIV_REQ  - four-phase divisor-load request
//   DIV_ACK  - four-phase divisor-load acknowledge
//   Z        - registered divided clock for the downstream clkbuf I pin
//   ACTIVE   - high while the divider is in RUN or DRAIN
//   VDD/VSS  - supply pins, carried for cell-level netlisting only

module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   DIV_RST = '0
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         EN,
  input  logic [W-1:0] DIV,
  input  logic         DIV_REQ,
  output logic         DIV_ACK,
  output logic         Z,
  output logic         ACTIVE,
  inout  wire          VDD,
  inout  wire          VSS
);

  // RUN   : producing periods, EN high
  // DRAIN : EN dropped mid-period; finishing the period before stopping
  // STOP  : parked, Z low, counter at zero
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [W:0] TWO = (W+1)'(2);
  localparam logic [W:0] ONE = (W+1)'(1);

  state_t       state_q, state_d;
  logic [W-1:0] sh_q, sh_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         z_q, z_d;
  logic         ack_q, ack_d;

  logic [W:0]   last_cnt;
  logic [W:0]   half_d;
  logic         wrap;
  logic         load_pending;

  // Supply pins have no logical function inside this model.
  wire unused_supply = VDD ^ VSS;

  // Counter is one bit wider than SH, so R-1 = SH+1 never overflows,
  // even at the maximum ratio 2^W+1.
  assign last_cnt     = {1'b0, sh_q} + ONE;
  assign wrap         = (cnt_q == last_cnt);
  assign load_pending = DIV_REQ && !ack_q;

  // High-phase length for the period that follows this edge. It uses the
  // next shadow value, so a divisor loaded on a wrap edge already shapes
  // the new period.
  assign half_d = ({1'b0, sh_d} + TWO) >> 1;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;

    // Return-to-zero phase of the handshake.
    if (ack_q && !DIV_REQ) begin
      ack_d = 1'b0;
    end

    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (load_pending) begin
          sh_d  = DIV;
          ack_d = 1'b1;
        end
        if (EN) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          // Period boundary: the only place where a load or a stop while
          // running is allowed to take effect.
          cnt_d = '0;
          if (load_pending) begin
            sh_d  = DIV;
            ack_d = 1'b1;
          end
          state_d = EN ? ST_RUN : ST_STOP;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = EN ? ST_RUN : ST_DRAIN;
        end
      end

      default: begin
        // Unused encoding: recover to a parked divider.
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase

    z_d = (state_d != ST_STOP) && (cnt_d < half_d);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_STOP;
      sh_q    <= DIV_RST;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
    end
  end

  assign Z       = z_q;
  assign DIV_ACK = ack_q;
  assign ACTIVE  = (state_q != ST_STOP);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1.sv - directed self-checking bench for the clock divider

module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1;

  localparam int W = 4;

  logic         CLK;
  logic         RN;
  logic         EN;
  logic [W-1:0] DIV;
  logic         DIV_REQ;
  logic         DIV_ACK;
  logic         Z;
  logic         ACTIVE;
  wire          vdd = 1'b1;
  wire          vss = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_1 #(
    .W       (W),
    .DIV_RST (4'd0)
  ) dut (
    .CLK     (CLK),
    .RN      (RN),
    .EN      (EN),
    .DIV     (DIV),
    .DIV_REQ (DIV_REQ),
    .DIV_ACK (DIV_ACK),
    .Z       (Z),
    .ACTIVE  (ACTIVE),
    .VDD     (vdd),
    .VSS     (vss)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check Z on each of the next n edges against bits[n-1:0], MSB first.
  task automatic expect_seq(input string tag, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick();
      check(tag, Z, bits[i]);
    end
  endtask

  // Full four-phase load issued while the divider is stopped.
  task automatic load_stopped(input logic [W-1:0] d);
    DIV     = d;
    DIV_REQ = 1'b1;
    tick();
    check("ack_rise", DIV_ACK, 1'b1);
    tick();
    check("ack_hold", DIV_ACK, 1'b1);
    DIV_REQ = 1'b0;
    tick();
    check("ack_fall", DIV_ACK, 1'b0);
  endtask

  initial begin
    RN      = 1'b0;
    EN      = 1'b1;
    DIV     = '0;
    DIV_REQ = 1'b0;

    // 1: reset held across an edge with EN=1, then default R=2.
    #12;
    check("rst_z", Z, 1'b0);
    check("rst_active", ACTIVE, 1'b0);
    check("rst_ack", DIV_ACK, 1'b0);
    @(posedge CLK);
    #1;
    RN = 1'b1;
    tick();
    check("r2_first_z", Z, 1'b1);
    check("r2_first_active", ACTIVE, 1'b1);
    expect_seq("r2_wave", 64'b010, 3);
    EN = 1'b0;
    tick();
    check("r2_stop_z", Z, 1'b0);
    check("r2_stop_active", ACTIVE, 1'b0);

    // 2: loads in STOP, R=6 then R=3.
    load_stopped(4'd4);
    EN = 1'b1;
    expect_seq("r6_wave", 64'b111000111000, 12);
    EN = 1'b0;
    tick();
    check("r6_stop_z", Z, 1'b0);
    check("r6_stop_active", ACTIVE, 1'b0);
    load_stopped(4'd1);
    EN = 1'b1;
    expect_seq("r3_wave", 64'b100100, 6);
    EN = 1'b0;
    tick();
    check("r3_stop_active", ACTIVE, 1'b0);

    // 3: mid-period reload from R=6 to R=4.
    load_stopped(4'd4);
    EN = 1'b1;
    expect_seq("reload_pre", 64'b11, 2);
    DIV     = 4'd2;
    DIV_REQ = 1'b1;
    tick();
    check("reload_cnt2_z", Z, 1'b1);
    check("reload_no_early_ack", DIV_ACK, 1'b0);
    expect_seq("reload_old_low", 64'b000, 3);
    check("reload_ack_before_wrap", DIV_ACK, 1'b0);
    tick();
    check("reload_wrap_z", Z, 1'b1);
    check("reload_wrap_ack", DIV_ACK, 1'b1);
    DIV_REQ = 1'b0;
    expect_seq("reload_new", 64'b1001100, 7);
    check("reload_ack_fall", DIV_ACK, 1'b0);
    EN = 1'b0;
    tick();
    check("reload_stop_active", ACTIVE, 1'b0);

    // 4: stop mid-period, then a drain cancelled before the wrap.
    load_stopped(4'd4);
    EN = 1'b1;
    expect_seq("drain_pre", 64'b11, 2);
    EN = 1'b0;
    expect_seq("drain_finish", 64'b1000, 4);
    check("drain_active", ACTIVE, 1'b1);
    tick();
    check("drain_end_z", Z, 1'b0);
    check("drain_end_active", ACTIVE, 1'b0);
    expect_seq("drain_parked", 64'b000, 3);
    EN = 1'b1;
    tick();
    check("restart_z", Z, 1'b1);
    EN = 1'b0;
    expect_seq("restart_drain", 64'b110, 3);
    check("restart_drain_active", ACTIVE, 1'b1);
    EN = 1'b1;
    expect_seq("restart_continuous", 64'b00111000, 8);

    // 5: async reset while Z and DIV_ACK are high.
    DIV     = 4'd4;
    DIV_REQ = 1'b1;
    tick();
    check("pre_rst_ack", DIV_ACK, 1'b1);
    tick();
    check("pre_rst_z", Z, 1'b1);
    #2;
    RN = 1'b0;
    #1;
    check("async_rst_z", Z, 1'b0);
    check("async_rst_ack", DIV_ACK, 1'b0);
    check("async_rst_active", ACTIVE, 1'b0);
    RN      = 1'b1;
    DIV_REQ = 1'b0;
    expect_seq("post_rst_r2", 64'b1010, 4);
    EN = 1'b0;
    tick();
    check("post_rst_stop", ACTIVE, 1'b0);

    // 6: maximum ratio R=17, then wrap with stop and load together.
    load_stopped(4'd15);
    EN = 1'b1;
    expect_seq("r17_wave", 64'b1111111100000000011111111000000000, 34);
    EN      = 1'b0;
    DIV     = 4'd3;
    DIV_REQ = 1'b1;
    tick();
    check("r17_stop_z", Z, 1'b0);
    check("r17_stop_active", ACTIVE, 1'b0);
    check("r17_stop_ack", DIV_ACK, 1'b1);
    DIV_REQ = 1'b0;
    tick();
    check("r17_ack_fall", DIV_ACK, 1'b0);
    EN = 1'b1;
    expect_seq("r5_wave", 64'b11000, 5);

    // Withdrawn request: raised and dropped within one period, no load.
    expect_seq("withdraw_pre", 64'b11, 2);
    DIV     = 4'd0;
    DIV_REQ = 1'b1;
    tick();
    check("withdraw_z", Z, 1'b0);
    check("withdraw_no_ack", DIV_ACK, 1'b0);
    DIV_REQ = 1'b0;
    expect_seq("withdraw_rest", 64'b00, 2);
    expect_seq("withdraw_r5_kept", 64'b11000, 5);
    check("withdraw_ack", DIV_ACK, 1'b0);
    EN = 1'b0;
    tick();
    check("final_stop_active", ACTIVE, 1'b0);
    check("final_stop_z", Z, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
